iopmp_err_capture: RTL and testbench

- Sits directly downstream of the IOPMP array/checker.
- Watches the per-channel violation flags and their error-report fields (transaction type, address, RRID, violated entry index).
- Arbitrates among channels that fail in the same cycle and latches the first violation into a software-visible error record, which is held until software clears it.
- Counts violations lost while a record is held and raises a level interrupt for the IOPMP register block.

---
 rtl/iopmp_err_capture.sv | 176 +++++++++++++++++
 tb/tb_iopmp_err_capture.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/iopmp_err_capture.sv
// IOPMP error capture: round-robin arbitrates per-channel violations into a
// single software-visible error record, counts lost violations, raises a level irq.
package top_pkg;
  localparam int SourceWidth = 8;
endpackage

module iopmp_err_capture #(
  parameter int IOPMPNumChan = 4,
  parameter int SourceWidth  = top_pkg::SourceWidth,
  parameter int AddrWidth    = 34,
  parameter int EidWidth     = 9,
  parameter int DropCntWidth = 8,
  localparam int ChanWidth   = (IOPMPNumChan > 1) ? $clog2(IOPMPNumChan) : 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [IOPMPNumChan-1:0]                  chan_err_i,
  input  logic [IOPMPNumChan-1:0][1:0]             chan_ttype_i,
  input  logic [IOPMPNumChan-1:0][AddrWidth-1:0]   chan_addr_i,
  input  logic [IOPMPNumChan-1:0][SourceWidth-1:0] chan_rrid_i,
  input  logic [IOPMPNumChan-1:0][EidWidth-1:0]    chan_eid_i,
  input  logic                                     err_clr_i,
  input  logic                                     intr_en_i,
  output logic                                     rec_valid_o,
  output logic [1:0]                               rec_ttype_o,
  output logic [3:0]                               rec_etype_o,
  output logic [AddrWidth-1:0]                     rec_addr_o,
  output logic [SourceWidth-1:0]                   rec_rrid_o,
  output logic [EidWidth-1:0]                      rec_eid_o,
  output logic [ChanWidth-1:0]                     rec_chan_o,
  output logic [DropCntWidth-1:0]                  drop_cnt_o,
  output logic                                     overflow_o,
  output logic                                     irq_o
);

  localparam int CntWidth = $clog2(IOPMPNumChan + 1);
  localparam int SumWidth = DropCntWidth + CntWidth + 1;
  localparam logic [DropCntWidth-1:0] DropMax = {DropCntWidth{1'b1}};

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_t;

  state_t                  state_reg;
  logic [ChanWidth-1:0]    ptr_reg;
  logic [ChanWidth-1:0]    ptr_next;
  logic [ChanWidth-1:0]    grant;
  logic                    any_err;
  logic [CntWidth-1:0]     pop;
  logic [1:0]              ttype_reg;
  logic [AddrWidth-1:0]    addr_reg;
  logic [SourceWidth-1:0]  rrid_reg;
  logic [EidWidth-1:0]     eid_reg;
  logic [ChanWidth-1:0]    chan_reg;
  logic [DropCntWidth-1:0] drop_reg;
  logic                    ovf_reg;
  logic [DropCntWidth-1:0] held_drop_next;
  logic [DropCntWidth-1:0] cap_drop_next;

  function automatic logic [DropCntWidth-1:0] sat_cnt(input logic [SumWidth-1:0] v);
    if (v > SumWidth'(DropMax)) begin
      return DropMax;
    end
    return v[DropCntWidth-1:0];
  endfunction

  // Round-robin search starting at ptr_reg, wrapping modulo the channel count.
  always_comb begin
    int idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    grant = '0;
    for (int k = 0; k < IOPMPNumChan; k++) begin
      idx = int'(ptr_reg) + k;
      if (idx >= IOPMPNumChan) begin
        idx = idx - IOPMPNumChan;
      end
      if (!found && chan_err_i[idx]) begin
        found = 1'b1;
        grant = ChanWidth'(idx);
      end
    end
  end

  assign ptr_next = (grant == ChanWidth'(IOPMPNumChan - 1)) ? '0 : grant + 1'b1;

  always_comb begin
    pop = '0;
    for (int k = 0; k < IOPMPNumChan; k++) begin
      pop = pop + CntWidth'(chan_err_i[k]);
    end
  end

  assign any_err = |chan_err_i;

  // Held: accumulate every flagged event. Capture: only same-cycle losers count.
  assign held_drop_next = sat_cnt(SumWidth'(drop_reg) + SumWidth'(pop));
  assign cap_drop_next  = any_err ? sat_cnt(SumWidth'(pop) - SumWidth'(1)) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      ttype_reg <= '0;
      addr_reg  <= '0;
      rrid_reg  <= '0;
      eid_reg   <= '0;
      chan_reg  <= '0;
      drop_reg  <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_err) begin
            state_reg <= HELD;
            ptr_reg   <= ptr_next;
            ttype_reg <= chan_ttype_i[grant];
            addr_reg  <= chan_addr_i[grant];
            rrid_reg  <= chan_rrid_i[grant];
            eid_reg   <= chan_eid_i[grant];
            chan_reg  <= grant;
            drop_reg  <= cap_drop_next;
            ovf_reg   <= (pop > CntWidth'(1));
          end
        end
        HELD: begin
          if (err_clr_i) begin
            if (any_err) begin
              // Clear and re-capture in the same cycle; stay held.
              ptr_reg   <= ptr_next;
              ttype_reg <= chan_ttype_i[grant];
              addr_reg  <= chan_addr_i[grant];
              rrid_reg  <= chan_rrid_i[grant];
              eid_reg   <= chan_eid_i[grant];
              chan_reg  <= grant;
              drop_reg  <= cap_drop_next;
              ovf_reg   <= (pop > CntWidth'(1));
            end else begin
              state_reg <= IDLE;
              drop_reg  <= '0;
              ovf_reg   <= 1'b0;
            end
          end else begin
            drop_reg <= held_drop_next;
            if (any_err) begin
              ovf_reg <= 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign rec_valid_o = (state_reg == HELD);
  assign rec_ttype_o = ttype_reg;
  assign rec_etype_o = {2'b00, ttype_reg};
  assign rec_addr_o  = addr_reg;
  assign rec_rrid_o  = rrid_reg;
  assign rec_eid_o   = eid_reg;
  assign rec_chan_o  = chan_reg;
  assign drop_cnt_o  = drop_reg;
  assign overflow_o  = ovf_reg;
  assign irq_o       = rec_valid_o & intr_en_i;

  valid_held_until_clear: assert property (
    @(posedge clk) disable iff (!rst)
    (rec_valid_o && !err_clr_i) |=> rec_valid_o);

  drop_cnt_monotonic: assert property (
    @(posedge clk) disable iff (!rst)
    (rec_valid_o && !err_clr_i) |=> (drop_cnt_o >= $past(drop_cnt_o)));

endmodule

// File: tb/tb_iopmp_err_capture.sv
// Directed bench for iopmp_err_capture with 4 channels; expected values are hand-derived.
module tb_iopmp_err_capture;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [3:0]       chan_err = '0;
  logic [3:0][1:0]  chan_ttype = '0;
  logic [3:0][33:0] chan_addr = '0;
  logic [3:0][7:0]  chan_rrid = '0;
  logic [3:0][8:0]  chan_eid = '0;
  logic             err_clr = 1'b0;
  logic             intr_en = 1'b0;
  logic             rec_valid;
  logic [1:0]       rec_ttype;
  logic [3:0]       rec_etype;
  logic [33:0]      rec_addr;
  logic [7:0]       rec_rrid;
  logic [8:0]       rec_eid;
  logic [1:0]       rec_chan;
  logic [7:0]       drop_cnt;
  logic             overflow;
  logic             irq;

  int checks = 0;
  int errors = 0;

  iopmp_err_capture #(
    .IOPMPNumChan(4),
    .SourceWidth (8),
    .AddrWidth   (34),
    .EidWidth    (9),
    .DropCntWidth(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .chan_err_i  (chan_err),
    .chan_ttype_i(chan_ttype),
    .chan_addr_i (chan_addr),
    .chan_rrid_i (chan_rrid),
    .chan_eid_i  (chan_eid),
    .err_clr_i   (err_clr),
    .intr_en_i   (intr_en),
    .rec_valid_o (rec_valid),
    .rec_ttype_o (rec_ttype),
    .rec_etype_o (rec_etype),
    .rec_addr_o  (rec_addr),
    .rec_rrid_o  (rec_rrid),
    .rec_eid_o   (rec_eid),
    .rec_chan_o  (rec_chan),
    .drop_cnt_o  (drop_cnt),
    .overflow_o  (overflow),
    .irq_o       (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // One clock edge; inputs are driven and outputs sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_chan(input int ch, input logic [1:0] tt, input logic [33:0] a,
                          input logic [7:0] r, input logic [8:0] e);
    chan_ttype[ch] = tt;
    chan_addr[ch]  = a;
    chan_rrid[ch]  = r;
    chan_eid[ch]   = e;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    for (int c = 0; c < 4; c++) begin
      set_chan(c, 2'd1, 34'h100 * (c + 1), 8'(8'h10 + c), 9'(9'h20 + c));
    end
    do_reset();
    intr_en = 1'b1;
    chk("reset_valid", 64'(rec_valid), 64'd0);
    chk("reset_drop",  64'(drop_cnt),  64'd0);
    chk("reset_irq",   64'(irq),       64'd0);

    // Clear in IDLE is ignored.
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("idle_clr_valid", 64'(rec_valid), 64'd0);

    // 1: single violation on channel 2
    repeat (8) step();
    set_chan(2, 2'd2, 34'h1_0000_0040, 8'd3, 9'd5);
    chan_err = 4'b0100; step(); chan_err = '0;
    chk("t1_valid", 64'(rec_valid), 64'd1);
    chk("t1_etype", 64'(rec_etype), 64'd2);
    chk("t1_addr",  64'(rec_addr),  64'h1_0000_0040);
    chk("t1_rrid",  64'(rec_rrid),  64'd3);
    chk("t1_eid",   64'(rec_eid),   64'd5);
    chk("t1_chan",  64'(rec_chan),  64'd2);
    chk("t1_drop",  64'(drop_cnt),  64'd0);
    chk("t1_ovf",   64'(overflow),  64'd0);
    chk("t1_irq_en", 64'(irq), 64'd1);
    intr_en = 1'b0; #1;
    chk("t1_irq_dis", 64'(irq), 64'd0);
    intr_en = 1'b1;

    // 2: all four at once from pointer 0, then again from pointer 1
    do_reset();
    set_chan(0, 2'd1, 34'h0_0000_0100, 8'h10, 9'h20);
    chan_err = 4'b1111; step(); chan_err = '0;
    chk("t2_chan0", 64'(rec_chan), 64'd0);
    chk("t2_addr0", 64'(rec_addr), 64'h100);
    chk("t2_drop0", 64'(drop_cnt), 64'd3);
    chk("t2_ovf0",  64'(overflow), 64'd1);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("t2_clr_valid", 64'(rec_valid), 64'd0);
    chan_err = 4'b1111; step(); chan_err = '0;
    chk("t2_chan1", 64'(rec_chan), 64'd1);
    chk("t2_drop1", 64'(drop_cnt), 64'd3);

    // 3: two losers per cycle while held; 3+2k saturates at 255
    chan_err = 4'b0011; step();
    chk("t3_drop_first", 64'(drop_cnt), 64'd5);
    chk("t3_ovf", 64'(overflow), 64'd1);
    repeat (199) step();
    chan_err = '0;
    chk("t3_drop_sat", 64'(drop_cnt), 64'd255);
    step();
    chk("t3_drop_hold", 64'(drop_cnt), 64'd255);
    chk("t3_chan", 64'(rec_chan), 64'd1);
    chk("t3_addr", 64'(rec_addr), 64'h200);
    chk("t3_rrid", 64'(rec_rrid), 64'h11);

    // 4: clear with no errors
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("t4_valid", 64'(rec_valid), 64'd0);
    chk("t4_drop",  64'(drop_cnt),  64'd0);
    chk("t4_ovf",   64'(overflow),  64'd0);
    chk("t4_irq",   64'(irq),       64'd0);
    chk("t4_stale_addr", 64'(rec_addr), 64'h200);

    // 5: clear + capture in one cycle, pointer at 3 then 0
    chan_err = 4'b0100; step(); chan_err = '0;
    chk("t5_pre_chan", 64'(rec_chan), 64'd2);
    set_chan(0, 2'd1, 34'h2000, 8'h40, 9'h041);
    set_chan(3, 2'd3, 34'h3_0000_3000, 8'h43, 9'h143);
    err_clr = 1'b1; chan_err = 4'b1001; step();
    err_clr = 1'b0; chan_err = '0;
    chk("t5a_valid", 64'(rec_valid), 64'd1);
    chk("t5a_chan",  64'(rec_chan),  64'd3);
    chk("t5a_etype", 64'(rec_etype), 64'd3);
    chk("t5a_addr",  64'(rec_addr),  64'h3_0000_3000);
    chk("t5a_drop",  64'(drop_cnt),  64'd1);
    chk("t5a_ovf",   64'(overflow),  64'd1);
    chan_err = 4'b1111; step(); chan_err = '0;
    chk("t5_accum", 64'(drop_cnt), 64'd5);
    err_clr = 1'b1; chan_err = 4'b1001; step();
    err_clr = 1'b0; chan_err = '0;
    chk("t5b_chan", 64'(rec_chan), 64'd0);
    chk("t5b_addr", 64'(rec_addr), 64'h2000);
    chk("t5b_eid",  64'(rec_eid),  64'h041);
    chk("t5b_drop", 64'(drop_cnt), 64'd1);

    // 6: asynchronous reset between edges, then capture on channel 1
    #2 rst = 1'b0;
    #1;
    chk("t6_valid", 64'(rec_valid), 64'd0);
    chk("t6_addr",  64'(rec_addr),  64'd0);
    chk("t6_chan",  64'(rec_chan),  64'd0);
    chk("t6_drop",  64'(drop_cnt),  64'd0);
    chk("t6_ovf",   64'(overflow),  64'd0);
    chk("t6_irq",   64'(irq),       64'd0);
    chk("t6_eid",   64'(rec_eid),   64'd0);
    step();
    rst = 1'b1;
    set_chan(1, 2'd0, 34'h1111, 8'h77, 9'h1ff);
    chan_err = 4'b0010; step(); chan_err = '0;
    chk("t6_cap_valid", 64'(rec_valid), 64'd1);
    chk("t6_cap_chan",  64'(rec_chan),  64'd1);
    chk("t6_cap_etype", 64'(rec_etype), 64'd0);
    chk("t6_cap_rrid",  64'(rec_rrid),  64'h77);
    chk("t6_cap_drop",  64'(drop_cnt),  64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
